mem_ctrl_arbiter: RTL
=====================

# mem_ctrl_arbiter

Sits between the two L1 caches (icache, dcache) and the single main-memory port, and arbitrates their block-level requests. It accepts one request at a time with icache priority and a dcache anti-starvation override. It forwards the request downstream, waits for the memory response, and returns a one-cycle response pulse to the originating cache. Every request gets exactly one response, reads and writes alike, because the caches clear their waiting state on response.

## Interface
- STARVE_LIMIT, default 4: consecutive icache grants while dcache waits, after which the dcache gets the next grant.
- clk  in  1  clock, all state on posedge.
- rst_aL  in  1  asynchronous, active-low reset.
- icache_req_valid  in  1  icache request.
- icache_req_type  in  req_type_t  READ/WRITE. Icache issues READ only; a WRITE is forwarded unchanged.
- icache_req_block_addr  in  main_mem_block_addr_t  block address.
- icache_req_block_data  in  block_data_t  write data, unused for READ.
- icache_req_ready  out  1  accept strobe.
- icache_resp_valid  out  1  one-cycle response pulse.
- icache_resp_block_data  out  block_data_t  read data, 0 for WRITE.
- dcache_req_valid / dcache_req_type / dcache_req_block_addr / dcache_req_block_data / dcache_req_ready / dcache_resp_valid / dcache_resp_block_data: same directions, widths and meanings as the icache ports.
- mem_req_valid  out  1  downstream request.
- mem_req_type  out  req_type_t.
- mem_req_block_addr  out  main_mem_block_addr_t.
- mem_req_block_data  out  block_data_t.
- mem_req_ready  in  1  downstream accept.
- mem_resp_valid  in  1  downstream response, one-cycle pulse, at least 1 cycle after acceptance.
- mem_resp_block_data  in  block_data_t.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - ISSUE: drives mem_req until accepted.
  - WAIT: waits for mem_resp_valid.
  - RESP: drives the cache response.
- Registered request (type, addr, data) and a 1-bit owner register (0 = icache, 1 = dcache). These are loaded on grant.
- Grant in IDLE:
  - starve = (starve_cnt == STARVE_LIMIT).
  - icache_req_ready = IDLE & ~(starve & dcache_req_valid).
  - dcache_req_ready = IDLE & (~icache_req_valid | starve).
  - At most one grant per cycle.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - +1 on an icache grant while dcache_req_valid = 1.
  - Cleared on a dcache grant.
  - Cleared on an icache grant while dcache_req_valid = 0.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - IDLE → ISSUE on a grant.
  - ISSUE → WAIT when mem_req_ready = 1.
  - WAIT → RESP on mem_resp_valid. Response data is captured into a register.
  - RESP → IDLE unconditionally.
- mem_req_valid = (state == ISSUE). The mem_req_* buses come from the request register and stay stable while in ISSUE.
- In RESP, the owner's resp_valid = 1 and the other cache's resp_valid = 0.
- Response data: captured data if the registered type is READ, 0 if WRITE. The non-owner's resp data is 0.
- mem_resp_valid outside WAIT is ignored. No state change occurs.
- Requests are not queued. A cache holds its valid until it sees ready.

## Timing
- Reset, asynchronous: state = IDLE; starve_cnt, owner, request and response registers = 0.
- Reset values of outputs:
  - mem_req_valid, both resp_valid = 0.
  - All data and address outputs = 0.
  - icache_req_ready / dcache_req_ready follow the IDLE equations.
- Reset mid-transaction: the outstanding request is dropped and no response is issued. Any downstream response that arrives later is ignored while in IDLE.
- Latency:
  - Grant at cycle T. mem_req_valid is high from T+1.
  - If mem_req_ready = 1 at T+1, the FSM enters WAIT at T+2.
  - mem_resp_valid at cycle R puts cache resp_valid at R+1.
  - A new grant is possible at R+2.
- Minimum grant-to-grant spacing is 4 cycles, with mem_req_ready tied high and the response 1 cycle after acceptance.
- ready is combinational from the valids and state. There is no combinational path from mem_resp_* to cache outputs.

## Test plan
- Icache READ alone:
  - Grant at T, addr 0x100.
  - mem_req_ready = 1, mem_resp at T+3 with data 0xDEADBEEF_CAFEF00D.
  - Required: icache_resp_valid one pulse at T+4 with that data; dcache_resp_valid stays 0.
- Simultaneous icache and dcache valid at IDLE, starve_cnt = 0:
  - Required: icache granted; dcache_req_ready = 0.
  - After the icache response, the dcache is granted at the next IDLE if the icache has dropped valid.
- Starvation, with STARVE_LIMIT = 4 and both valids held high continuously:
  - Required: 4 icache grants, then a dcache grant on the 5th with icache_req_ready = 0 that cycle; starve_cnt returns to 0.
- Dcache WRITE, data 0x1122334455667788:
  - mem_req_ready held 0 for 3 cycles.
  - Required: mem_req_* stable during the stall; one dcache_resp_valid pulse with data 0.
- Reset asserted in WAIT, then a stray mem_resp_valid after release:
  - Required: no cache resp_valid; state IDLE; all outputs at reset values.
- mem_resp_valid pulsed in IDLE and in ISSUE:
  - Required: ignored; no resp_valid; FSM unaffected.

Source files
------------

// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// mem_ctrl_arbiter : icache/dcache arbiter in front of the main-memory port
// Revision: 1.0
// ============================================================================

package mem_ctrl_arbiter_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
  typedef logic [31:0] main_mem_block_addr_t;
  typedef logic [63:0] block_data_t;
endpackage

module mem_ctrl_arbiter
  import mem_ctrl_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_aL,

  input  logic                 icache_req_valid,
  input  req_type_t            icache_req_type,
  input  main_mem_block_addr_t icache_req_block_addr,
  input  block_data_t          icache_req_block_data,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,

  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data,

  output logic                 mem_req_valid,
  output req_type_t            mem_req_type,
  output main_mem_block_addr_t mem_req_block_addr,
  output block_data_t          mem_req_block_data,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  block_data_t          mem_resp_block_data
);

  localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_starve_cnt;
  logic                 r_owner;
  req_type_t            r_req_type;
  main_mem_block_addr_t r_req_addr;
  block_data_t          r_req_data;
  logic                 r_mem_req_valid;
  logic                 r_icache_resp_valid;
  logic                 r_dcache_resp_valid;
  block_data_t          r_icache_resp_data;
  block_data_t          r_dcache_resp_data;

  logic w_idle;
  logic w_starve;
  logic w_icache_grant;
  logic w_dcache_grant;

  assign w_idle   = (r_state == IDLE);
  assign w_starve = (r_starve_cnt == c_STARVE_MAX);

  // The two ready terms are mutually exclusive whenever both caches are valid.
  assign icache_req_ready = w_idle & ~(w_starve & dcache_req_valid);
  assign dcache_req_ready = w_idle & (~icache_req_valid | w_starve);

  assign w_icache_grant = icache_req_valid & icache_req_ready;
  assign w_dcache_grant = dcache_req_valid & dcache_req_ready & ~w_icache_grant;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state             <= IDLE;
      r_starve_cnt        <= '0;
      r_owner             <= 1'b0;
      r_req_type          <= READ;
      r_req_addr          <= '0;
      r_req_data          <= '0;
      r_mem_req_valid     <= 1'b0;
      r_icache_resp_valid <= 1'b0;
      r_dcache_resp_valid <= 1'b0;
      r_icache_resp_data  <= '0;
      r_dcache_resp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_icache_grant) begin
            r_owner         <= 1'b0;
            r_req_type      <= icache_req_type;
            r_req_addr      <= icache_req_block_addr;
            r_req_data      <= icache_req_block_data;
            r_mem_req_valid <= 1'b1;
            r_state         <= ISSUE;
            if (!dcache_req_valid) begin
              r_starve_cnt <= '0;
            end else if (!w_starve) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else if (w_dcache_grant) begin
            r_owner         <= 1'b1;
            r_req_type      <= dcache_req_type;
            r_req_addr      <= dcache_req_block_addr;
            r_req_data      <= dcache_req_block_data;
            r_mem_req_valid <= 1'b1;
            r_starve_cnt    <= '0;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            // Write responses carry no data back to the cache.
            r_icache_resp_valid <= ~r_owner;
            r_dcache_resp_valid <= r_owner;
            r_icache_resp_data  <= (!r_owner && r_req_type == READ) ? mem_resp_block_data : '0;
            r_dcache_resp_data  <= (r_owner && r_req_type == READ) ? mem_resp_block_data : '0;
            r_state             <= RESP;
          end
        end
        RESP: begin
          r_icache_resp_valid <= 1'b0;
          r_dcache_resp_valid <= 1'b0;
          r_icache_resp_data  <= '0;
          r_dcache_resp_data  <= '0;
          r_state             <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid          = r_mem_req_valid;
  assign mem_req_type           = r_req_type;
  assign mem_req_block_addr     = r_req_addr;
  assign mem_req_block_data     = r_req_data;
  assign icache_resp_valid      = r_icache_resp_valid;
  assign icache_resp_block_data = r_icache_resp_data;
  assign dcache_resp_valid      = r_dcache_resp_valid;
  assign dcache_resp_block_data = r_dcache_resp_data;

endmodule

`default_nettype wire
